// File: rtl/ap_ctrl_perf_monitor.sv
// Multi-channel ap_ctrl_hs/ap_ctrl_chain handshake monitor: per-channel transaction,
// latency, interval and back-pressure statistics with a registered select readout.
module ap_ctrl_perf_monitor #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned CH_W  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_CH-1:0]  ap_start,
    input  logic [N_CH-1:0]  ap_ready,
    input  logic [N_CH-1:0]  ap_done,
    input  logic [N_CH-1:0]  ap_continue,
    input  logic             finish,
    input  logic [CH_W-1:0]  rd_ch,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             frozen,
    output logic [N_CH-1:0]  busy
);

    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic [N_CH-1:0][CNT_W-1:0] ch_val;
    logic [CNT_W-1:0]           sel_val;

    // Sticky freeze; only reset releases it.
    always_ff @(posedge clock) begin
        if (reset) begin
            frozen <= 1'b0;
        end else if (finish) begin
            frozen <= 1'b1;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] start_cnt;
        logic [CNT_W-1:0] done_cnt;
        logic [CNT_W-1:0] stall_cnt;
        logic [CNT_W-1:0] last_lat;
        logic [CNT_W-1:0] max_lat;
        logic [CNT_W-1:0] min_lat;
        logic [CNT_W-1:0] last_int;
        logic [CNT_W-1:0] lat_cnt;
        logic [CNT_W-1:0] lat_nxt;
        logic [CNT_W-1:0] int_cnt;
        logic [CNT_W-1:0] rec_lat;
        logic [CNT_W-1:0] val;
        logic             rec;
        logic             lat_vld;
        logic             armed;
        logic             busy_q;
        logic             accept;

        assign accept = ap_start[c] & ap_ready[c];

        // Transaction FSM: latency is inclusive from the start cycle to the done cycle.
        always_comb begin
            state_nxt = state;
            lat_nxt   = lat_cnt;
            rec       = 1'b0;
            rec_lat   = lat_cnt;
            unique case (state)
                IDLE: begin
                    if (ap_start[c]) begin
                        lat_nxt   = CNT_ONE;
                        state_nxt = BUSY;
                        if (ap_done[c]) begin
                            rec       = 1'b1;
                            rec_lat   = CNT_ONE;
                            state_nxt = ap_continue[c] ? IDLE : HOLD;
                        end
                    end
                end
                BUSY: begin
                    lat_nxt = sat_inc(lat_cnt);
                    if (ap_done[c]) begin
                        rec       = 1'b1;
                        rec_lat   = sat_inc(lat_cnt);
                        state_nxt = ap_continue[c] ? IDLE : HOLD;
                    end
                end
                HOLD: begin
                    if (ap_continue[c]) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else if (!frozen) begin
                state  <= state_nxt;
                busy_q <= (state_nxt != IDLE);
            end
        end

        // Statistics; acceptance and completion counters run independently of the FSM.
        always_ff @(posedge clock) begin
            if (reset) begin
                start_cnt <= '0;
                done_cnt  <= '0;
                stall_cnt <= '0;
                last_lat  <= '0;
                max_lat   <= '0;
                min_lat   <= CNT_MAX;
                last_int  <= '0;
                lat_cnt   <= '0;
                int_cnt   <= '0;
                lat_vld   <= 1'b0;
                armed     <= 1'b0;
            end else if (!frozen) begin
                lat_cnt <= lat_nxt;
                if (accept) begin
                    start_cnt <= sat_inc(start_cnt);
                    if (armed) begin
                        last_int <= int_cnt;
                    end
                    int_cnt <= CNT_ONE;
                    armed   <= 1'b1;
                end else if (armed) begin
                    int_cnt <= sat_inc(int_cnt);
                end
                if (ap_done[c] & ap_continue[c]) begin
                    done_cnt <= sat_inc(done_cnt);
                end
                if (state == HOLD) begin
                    stall_cnt <= sat_inc(stall_cnt);
                end
                if (rec) begin
                    last_lat <= rec_lat;
                    lat_vld  <= 1'b1;
                    if (rec_lat > max_lat) begin
                        max_lat <= rec_lat;
                    end
                    if (rec_lat < min_lat) begin
                        min_lat <= rec_lat;
                    end
                end
            end
        end

        always_comb begin
            val = '0;
            case (rd_sel)
                3'd0:    val = start_cnt;
                3'd1:    val = done_cnt;
                3'd2:    val = last_lat;
                3'd3:    val = max_lat;
                3'd4:    val = lat_vld ? min_lat : '0;
                3'd5:    val = stall_cnt;
                3'd6:    val = last_int;
                default: val = CNT_W'({state, frozen});
            endcase
        end

        assign ch_val[c] = val;
        assign busy[c]   = busy_q;
    end

    // Out-of-range channel selects fall through to zero.
    always_comb begin
        sel_val = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (32'(rd_ch) == i) begin
                sel_val = ch_val[IDX_W'(i)];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= sel_val;
        end
    end

endmodule

// File: doc/ap_ctrl_perf_monitor.md
Name: ap_ctrl_perf_monitor

Overview:
Synthesizable, parametrised multi-channel monitor for ap_ctrl_hs/ap_ctrl_chain block-level handshakes (ap_start/ap_ready/ap_done/ap_continue). It taps N_CH module interfaces in the FIR wrapper hierarchy (top wrapper plus submodules) and tracks per-channel transaction counts, latency, interval and ap_continue back-pressure. Statistics freeze on finish and are read through a registered select port, in cosim or on-chip.

Parameters:
N_CH, 2, number of monitored module interfaces (1..16)
CNT_W, 32, width of every counter/statistic; all saturate at 2^CNT_W-1
CH_W, 4, width of rd_ch select (2^CH_W >= N_CH)

Ports:
clock  in  1  single clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
ap_start  in  N_CH  per-channel ap_start tap
ap_ready  in  N_CH  per-channel ap_ready tap
ap_done  in  N_CH  per-channel ap_done tap
ap_continue  in  N_CH  per-channel ap_continue tap (tie 1 for ap_ctrl_hs)
finish  in  1  end of test; sticky freeze request
rd_ch  in  CH_W  channel select for readout
rd_sel  in  3  statistic select
rd_data  out  CNT_W  registered statistic value
frozen  out  1  sticky, high from cycle after finish sampled
busy  out  N_CH  per-channel: state != IDLE

Behaviour:
- Reset (synchronous, clock edge with reset=1): all channels IDLE, all counters 0, min_lat = all-ones, frozen=0, rd_data=0, busy=0. Reset overrides finish and frozen.
- Per-channel FSM, states IDLE, BUSY, HOLD:
  - IDLE: ap_start=1 -> BUSY, lat_cnt=1. If ap_done=1 in the same cycle: record latency 1, then go to IDLE if ap_continue=1, else HOLD.
  - BUSY: lat_cnt+1 (saturating) each cycle. On ap_done=1: record latency = lat_cnt+1, the inclusive count from the start cycle to the done cycle. Then go to IDLE if ap_continue=1, else HOLD.
  - HOLD: stall_cnt+1 each cycle. ap_continue=1 -> IDLE. ap_done is not re-recorded.
- start_cnt +1 on every cycle with ap_start & ap_ready. This counts pipelined (II<latency) acceptances independently of the FSM.
- done_cnt +1 on every cycle with ap_done & ap_continue.
- Recording latency L updates last_lat=L, max_lat=max(max_lat,L) and min_lat=min(min_lat,L).
- Interval: int_cnt counts cycles since the previous ap_start&ap_ready. On each acceptance after the first: last_interval=int_cnt, then int_cnt resets to 1. The first acceptance only arms int_cnt. Back-to-back acceptances give interval 1.
- Saturation: no counter wraps; all hold at all-ones.
- Freeze: finish=1 at an edge sets frozen from the next cycle. While frozen, FSMs and all counters hold. Readout stays live. Only reset clears frozen.
- Readout: rd_data updates one cycle after rd_ch/rd_sel; both may change every cycle.
  - rd_sel: 0 start_cnt, 1 done_cnt, 2 last_lat, 3 max_lat, 4 min_lat (0 if no latency recorded yet), 5 stall_cnt, 6 last_interval, 7 status.
  - status = {zero-extended, state[1:0] (IDLE=0, BUSY=1, HOLD=2), frozen}.
  - rd_ch >= N_CH returns 0.
- Channels are fully independent. Simultaneous events on different channels are all captured in the same cycle.

Test Plan:
- Reset, then single transaction on ch0: start at t=10 held until done at t=14, continue=1 -> start_cnt=1, done_cnt=1, last_lat=max_lat=min_lat=5, stall_cnt=0, busy[0] high t=11..14.
- ap_ctrl_chain on ch1: done at t=20, continue low t=20..22, high t=23 -> stall_cnt=3 (HOLD t=21..23), done_cnt=1 only after t=23, last_lat unchanged by HOLD cycles.
- Pipelined ch0: ap_start=ap_ready=1 on three consecutive cycles, then every 4th cycle twice -> start_cnt=5, last_interval=4; start+done same cycle in IDLE -> last_lat=1, min_lat=1.
- Latencies 7, 3, 9 on ch0 -> last_lat=9, max_lat=9, min_lat=3; rd_ch=N_CH -> rd_data=0 one cycle later.
- finish pulsed mid-transaction on ch1 (BUSY), further done/start toggling -> frozen=1 next cycle, counters unchanged, status reads state=1, frozen=1; reset then -> all zero, min_lat reads 0.
- CNT_W=4 build: 20 accepted starts -> start_cnt=15 (saturated, no wrap).
